memcoll_port_arbiter: RTL and testbench
=======================================

Name: memcoll_port_arbiter

Overview:
- Per-collection access arbiter in front of mem_collection, whose memories are single-port and read-first.
- Two clients per collection share the one port that drives all z memories of that collection:
  - a read client (feedforward fetch);
  - a write client (weight update).
- Grants at most one client per collection per cycle, using alternating priority under contention.
- Returns read data with a registered valid strobe, one cycle after grant.

Parameters:
- collection, 2: number of collections; one independent arbiter per collection.
- z, 2: memories per collection.
- depth, 2: cells per memory.
- width, 4: bits per cell.
- addrsize, localparam: (depth==1) ? 1 : $clog2(depth).

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- rd_req  input  [collection-1:0]  read request, one per collection.
- rd_addr  input  [addrsize-1:0] x [collection]  read cell address, shared by all z mems of the collection.
- rd_grant  output  [collection-1:0]  combinational; read accepted this cycle.
- rd_valid  output  [collection-1:0]  registered; rd_data valid this cycle.
- rd_data  output  [width-1:0] x [collection][z]  passthrough of mem data_out.
- wr_req  input  [collection-1:0]  write request.
- wr_addr  input  [addrsize-1:0] x [collection][z]  per-memory write address.
- wr_mask  input  [z-1:0] x [collection]  per-memory write enable.
- wr_data  input  [width-1:0] x [collection][z]  write data.
- wr_grant  output  [collection-1:0]  combinational; write accepted this cycle.
- address  output  [addrsize-1:0] x [collection][z]  to mem_collection.
- we  output  [z-1:0] x [collection]  to mem_collection.
- data_in  output  [width-1:0] x [collection][z]  to mem_collection.
- data_out  input  [width-1:0] x [collection][z]  from mem_collection.

Behaviour:

State and reset:
- One state bit per collection: pri[c], where 0 = read preferred and 1 = write preferred.
- Reset values:
  - pri = 0.
  - rd_valid = 0.
  - rd_grant, wr_grant, we forced 0 while reset is high.
  - address and data_in driven 0 while reset is high.

Grant logic (combinational, per collection c, when not in reset):
- Only rd_req[c]: rd_grant=1.
- Only wr_req[c]: wr_grant=1.
- Both requesting: grant read if pri[c]=0, else grant write.
- Neither requesting: no grant.
- rd_grant[c] and wr_grant[c] are never both 1.

Memory drive:
- Read grant: address[c][j]=rd_addr[c] for all j; we[c]=0.
- Write grant: address[c][j]=wr_addr[c][j]; we[c]=wr_mask[c]; data_in[c][j]=wr_data[c][j].
- Idle: address=0, we=0, data_in=0.
- wr_mask=0 with a write grant is legal: the slot is consumed, nothing is written.

Priority update (posedge):
- Only on a contended cycle (both requests high): pri[c] toggles to the opposite of the client just granted.
- Uncontended cycles leave pri[c] unchanged.
- Result: each client waits at most 1 cycle under continuous contention.

Read latency:
- rd_valid[c] <= rd_grant[c].
- rd_data is data_out directly; it equals the cell content before the granted edge (read-first, 1-cycle latency).
- Back-to-back read grants give rd_valid high on consecutive cycles (full throughput).

Handshake:
- A requester holds req and its address/data stable until it sees grant high in the same cycle.
- Request is consumed at the posedge where grant=1.
- The arbiter does not latch requests.

Boundaries:
- Read after write to the same cell, on consecutive grants: returns the new data.
- Read and write contending for the same cell: order follows pri.
- Collections are fully independent; no cross-collection interaction.
- Reset mid-operation: rd_valid clears on the next edge, any in-flight read is dropped, pri returns to 0.
- Address range is not checked; addresses are always within addrsize bits.

Test Plan:
1. Reset 2 cycles, then c0 wr_req with wr_mask=11, wr_addr=0, wr_data={1,2}; c1 wr_req with wr_mask=11, wr_addr={0,1}, wr_data={2,3} -> wr_grant=11 the same cycle, we=11 per collection, rd_valid=00.
2. Next cycle rd_req=11, rd_addr c0=0, c1=0 -> rd_grant=11; next cycle rd_valid=11, rd_data c0={1,2}, c1={2,0}.
3. c0 rd_req and wr_req held high for 4 cycles (wr_mask=10, wr_data m1=a) -> grants R,W,R,W; pri toggles each cycle; the 2nd read returns m1=a.
4. Only wr_req held 3 cycles on c1 -> wr_grant every cycle, pri unchanged at 0; then contention -> read granted first.
5. Assert reset in the cycle after a read grant -> rd_valid=0 on the next edge, grants and we=0 during reset, pri=0 afterwards.
6. Random req/addr on both collections for 500 cycles against a scoreboard memory model -> rd_data matches on every rd_valid, never two grants in one collection, and no client waits more than 1 cycle under contention.

Source files
------------

// File: rtl/memcoll_port_arbiter.sv
// Per-collection arbiter sharing one single-port, read-first memory port between a
// read client and a write client, with alternating priority under contention.
module memcoll_port_arbiter #(
  parameter int unsigned collection = 2,
  parameter int unsigned z          = 2,
  parameter int unsigned depth      = 2,
  parameter int unsigned width      = 4,
  localparam int unsigned addrsize  = (depth == 1) ? 1 : $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [collection-1:0] rd_req,
  input  logic [addrsize-1:0]   rd_addr  [collection],
  output logic [collection-1:0] rd_grant,
  output logic [collection-1:0] rd_valid,
  output logic [width-1:0]      rd_data  [collection][z],
  input  logic [collection-1:0] wr_req,
  input  logic [addrsize-1:0]   wr_addr  [collection][z],
  input  logic [z-1:0]          wr_mask  [collection],
  input  logic [width-1:0]      wr_data  [collection][z],
  output logic [collection-1:0] wr_grant,
  output logic [addrsize-1:0]   address  [collection][z],
  output logic [z-1:0]          we       [collection],
  output logic [width-1:0]      data_in  [collection][z],
  input  logic [width-1:0]      data_out [collection][z]
);

  // pri_q[c]: 0 = read preferred, 1 = write preferred
  logic [collection-1:0] pri_q, pri_d;
  logic [collection-1:0] rd_valid_q, rd_valid_d;
  logic [collection-1:0] rd_g, wr_g;

  always_comb begin
    rd_g       = '0;
    wr_g       = '0;
    pri_d      = pri_q;
    rd_valid_d = '0;
    for (int c = 0; c < collection; c++) begin
      we[c] = '0;
      for (int j = 0; j < z; j++) begin
        address[c][j] = '0;
        data_in[c][j] = '0;
      end
      if (!reset) begin
        rd_g[c] = rd_req[c] & (~wr_req[c] | ~pri_q[c]);
        wr_g[c] = wr_req[c] & ~rd_g[c];
        // After contention the loser gets preference next time
        if (rd_req[c] && wr_req[c]) begin
          pri_d[c] = rd_g[c];
        end
        rd_valid_d[c] = rd_g[c];
        if (rd_g[c]) begin
          for (int j = 0; j < z; j++) begin
            address[c][j] = rd_addr[c];
          end
        end else if (wr_g[c]) begin
          we[c] = wr_mask[c];
          for (int j = 0; j < z; j++) begin
            address[c][j] = wr_addr[c][j];
            data_in[c][j] = wr_data[c][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      pri_q      <= pri_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_grant = rd_g;
  assign wr_grant = wr_g;
  assign rd_valid = rd_valid_q;
  assign rd_data  = data_out;

endmodule

// File: tb/tb_memcoll_port_arbiter.sv
// Directed vector table plus a randomized scoreboard run for memcoll_port_arbiter,
// with a behavioural read-first memory collection attached to the memory port.
module tb_memcoll_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rd_req, wr_req, rd_grant, wr_grant, rd_valid;
  logic [0:0] rd_addr  [2];
  logic [3:0] rd_data  [2][2];
  logic [0:0] wr_addr  [2][2];
  logic [1:0] wr_mask  [2];
  logic [3:0] wr_data  [2][2];
  logic [0:0] address  [2][2];
  logic [1:0] we       [2];
  logic [3:0] data_in  [2][2];
  logic [3:0] data_out [2][2];

  logic [3:0] mem [2][2][2];
  logic [3:0] sb  [2][2][2];
  logic       mem_clr = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memcoll_port_arbiter #(
    .collection(2),
    .z         (2),
    .depth     (2),
    .width     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_grant(rd_grant),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_mask (wr_mask),
    .wr_data (wr_data),
    .wr_grant(wr_grant),
    .address (address),
    .we      (we),
    .data_in (data_in),
    .data_out(data_out)
  );

  // Read-first single-port memories, registered output
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < 2; j++) begin
        if (mem_clr) begin
          mem[c][j][0] <= 4'h0;
          mem[c][j][1] <= 4'h0;
          data_out[c][j] <= 4'h0;
        end else begin
          data_out[c][j] <= mem[c][j][address[c][j]];
          if (we[c][j]) mem[c][j][address[c][j]] <= data_in[c][j];
        end
      end
    end
  end

  typedef struct {
    logic        rst;
    logic [1:0]  rdr, wrr, ra;
    logic [3:0]  wa, wm;
    logic [15:0] wd;
    logic [1:0]  e_rg, e_wg;
    logic [3:0]  e_we;
    logic [1:0]  e_rv;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_rd();
    return {rd_data[1][1], rd_data[1][0], rd_data[0][1], rd_data[0][0]};
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst;
    rd_req = v.rdr;
    wr_req = v.wrr;
    for (int c = 0; c < 2; c++) begin
      rd_addr[c] = v.ra[c];
      wr_mask[c] = v.wm[c*2 +: 2];
      for (int j = 0; j < 2; j++) begin
        wr_addr[c][j] = v.wa[c*2+j];
        wr_data[c][j] = v.wd[(c*2+j)*4 +: 4];
      end
    end
  endtask

  logic [1:0]  pri_m, ev_m, mr, mw;
  logic [3:0]  ed_m [2][2];
  int          rw [2];
  int          ww [2];
  logic [15:0] msk;

  initial begin
    //              rst rdr    wrr    ra     wa       wm       wd        e_rg   e_wg   e_we     e_rv   e_rd
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 16'h0000, 2'b00, 2'b00, 4'b0000, 2'b00, 16'h0000};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1'b0, 2'b00, 2'b11, 2'b00, 4'b1000, 4'b1111, 16'h3221, 2'b00, 2'b11, 4'b1111, 2'b00, 16'h0000};
    vecs[3]  = '{1'b0, 2'b11, 2'b00, 2'b00, 4'b0000, 4'b0000, 16'h0000, 2'b11, 2'b00, 4'b0000, 2'b00, 16'h0000};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 16'h0000, 2'b00, 2'b00, 4'b0000, 2'b11, 16'h0221};
    vecs[5]  = '{1'b0, 2'b01, 2'b01, 2'b01, 4'b0010, 4'b0010, 16'h00a0, 2'b01, 2'b00, 4'b0000, 2'b00, 16'h0000};
    vecs[6]  = '{1'b0, 2'b01, 2'b01, 2'b01, 4'b0010, 4'b0010, 16'h00a0, 2'b00, 2'b01, 4'b0010, 2'b01, 16'h0000};
    vecs[7]  = '{1'b0, 2'b01, 2'b01, 2'b01, 4'b0010, 4'b0010, 16'h00a0, 2'b01, 2'b00, 4'b0000, 2'b00, 16'h0000};
    vecs[8]  = '{1'b0, 2'b01, 2'b01, 2'b01, 4'b0010, 4'b0010, 16'h00a0, 2'b00, 2'b01, 4'b0010, 2'b01, 16'h00a0};
    vecs[9]  = '{1'b0, 2'b00, 2'b10, 2'b00, 4'b0100, 4'b1100, 16'h6500, 2'b00, 2'b10, 4'b1100, 2'b00, 16'h0000};
    vecs[10] = vecs[9];
    vecs[11] = vecs[9];
    vecs[12] = '{1'b0, 2'b10, 2'b10, 2'b10, 4'b0100, 4'b1100, 16'h6500, 2'b10, 2'b00, 4'b0000, 2'b00, 16'h0000};
    vecs[13] = '{1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 16'h0000, 2'b00, 2'b00, 4'b0000, 2'b10, 16'h3500};
    vecs[14] = '{1'b0, 2'b10, 2'b00, 2'b00, 4'b0000, 4'b0000, 16'h0000, 2'b10, 2'b00, 4'b0000, 2'b00, 16'h0000};
    vecs[15] = '{1'b1, 2'b11, 2'b11, 2'b00, 4'b0000, 4'b1111, 16'h1111, 2'b00, 2'b00, 4'b0000, 2'b10, 16'h6200};
    vecs[16] = '{1'b0, 2'b11, 2'b11, 2'b00, 4'b0000, 4'b0000, 16'h0000, 2'b11, 2'b00, 4'b0000, 2'b00, 16'h0000};
    vecs[17] = '{1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 16'h0000, 2'b00, 2'b00, 4'b0000, 2'b11, 16'h6221};

    apply(vecs[0]);
    @(posedge clk);
    #1 mem_clr = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d rd_grant", i), 32'(rd_grant), 32'(vecs[i].e_rg));
      chk($sformatf("v%0d wr_grant", i), 32'(wr_grant), 32'(vecs[i].e_wg));
      chk($sformatf("v%0d we", i), 32'({we[1], we[0]}), 32'(vecs[i].e_we));
      chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv != 2'b00) begin
        msk = {{8{vecs[i].e_rv[1]}}, {8{vecs[i].e_rv[0]}}};
        chk($sformatf("v%0d rd_data", i), 32'(pack_rd() & msk), 32'(vecs[i].e_rd & msk));
      end
      @(posedge clk);
      #1;
    end

    // Randomized phase: both collections saw a contended read grant last, so pri = 11
    pri_m = 2'b11;
    ev_m  = 2'b00;
    mr    = 2'b00;
    mw    = 2'b00;
    sb    = mem;
    rd_req = 2'b00;
    wr_req = 2'b00;
    for (int c = 0; c < 2; c++) begin
      rw[c] = 0;
      ww[c] = 0;
    end
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(rd_req[c] && !mr[c])) begin
          rd_req[c]  = 1'($urandom_range(0, 1));
          rd_addr[c] = 1'($urandom_range(0, 1));
        end
        if (!(wr_req[c] && !mw[c])) begin
          wr_req[c]  = 1'($urandom_range(0, 1));
          wr_mask[c] = 2'($urandom_range(0, 3));
          for (int j = 0; j < 2; j++) begin
            wr_addr[c][j] = 1'($urandom_range(0, 1));
            wr_data[c][j] = 4'($urandom_range(0, 15));
          end
        end
      end
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        mr[c] = rd_req[c] & (~wr_req[c] | ~pri_m[c]);
        mw[c] = wr_req[c] & ~mr[c];
        chk($sformatf("r%0d c%0d rd_grant", n, c), 32'(rd_grant[c]), 32'(mr[c]));
        chk($sformatf("r%0d c%0d wr_grant", n, c), 32'(wr_grant[c]), 32'(mw[c]));
        chk($sformatf("r%0d c%0d two_grants", n, c), 32'(rd_grant[c] & wr_grant[c]), 32'd0);
        chk($sformatf("r%0d c%0d rd_valid", n, c), 32'(rd_valid[c]), 32'(ev_m[c]));
        if (ev_m[c]) begin
          chk($sformatf("r%0d c%0d rd_data", n, c), 32'({rd_data[c][1], rd_data[c][0]}),
              32'({ed_m[c][1], ed_m[c][0]}));
        end
        if (mw[c]) begin
          chk($sformatf("r%0d c%0d we", n, c), 32'(we[c]), 32'(wr_mask[c]));
        end
        if (!mr[c] && !mw[c]) begin
          chk($sformatf("r%0d c%0d idle_port", n, c),
              32'({we[c], address[c][1], address[c][0], data_in[c][1], data_in[c][0]}), 32'd0);
        end
        rw[c] = (rd_req[c] && !rd_grant[c]) ? rw[c] + 1 : 0;
        ww[c] = (wr_req[c] && !wr_grant[c]) ? ww[c] + 1 : 0;
        chk($sformatf("r%0d c%0d rd_wait", n, c), 32'(rw[c] > 1), 32'd0);
        chk($sformatf("r%0d c%0d wr_wait", n, c), 32'(ww[c] > 1), 32'd0);
        // Advance the model to the coming edge
        if (rd_req[c] && wr_req[c]) pri_m[c] = mr[c];
        ev_m[c] = mr[c];
        for (int j = 0; j < 2; j++) begin
          if (mr[c]) ed_m[c][j] = sb[c][j][rd_addr[c]];
          if (mw[c] && wr_mask[c][j]) sb[c][j][wr_addr[c][j]] = wr_data[c][j];
        end
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
